cdc_handshake_sync: RTL and testbench
=====================================

Name: cdc_handshake_sync

Overview:
- Single-clock model of a four-phase req/ack clock-domain-crossing handshake.
- An internal sender generates an incrementing DATA_W-bit payload.
- The payload is delivered to an internal receiver through SYNC_STAGES-deep synchronizers on req and ack. The receiver publishes each completed transfer on data_out.
- Used as the reference transfer engine for CDC experiments. It is gated by an asynchronous data_ready enable.

Parameters:
- DATA_W, 6, payload and data_out width.
- SYNC_STAGES, 2, flop stages in each synchronizer (data_ready, req, ack). Minimum 2.
- START_VAL, 0, first payload value sent after reset.

Ports:
- pclk  input  1  sole clock; all flops on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- data_ready  input  1  asynchronous level enable for transfers; must be synchronized before use.
- data_out  output  DATA_W  last payload received; registered.

Behaviour:
- Interface: one clock (pclk); reset rst_n is synchronous and active-low. No other clocks; no asynchronous reset paths.
- Reset (rst_n=0 at a pclk edge) sets:
  - data_out=0
  - src_data=START_VAL
  - req=0, ack=0
  - all synchronizer flops=0
  - both FSMs idle
- Reset mid-transfer aborts the transfer: no data_out update, and src_data does not increment.
- rdy_s: data_ready passed through SYNC_STAGES flops.
- req_s: req passed through SYNC_STAGES flops.
- ack_s: ack passed through SYNC_STAGES flops.
- Sender FSM:
  - S_IDLE: if rdy_s=1, set req<=1 and go to S_REQ. Otherwise stay.
  - S_REQ: hold req=1 and keep src_data stable. When ack_s=1, set req<=0, src_data<=src_data+1 (modulo 2^DATA_W, so 63->0), and go to S_WACK.
  - S_WACK: when ack_s=0, go to S_IDLE.
- Receiver FSM:
  - R_IDLE: when req_s=1, set data_out<=src_data, ack<=1, and go to R_ACK.
  - R_ACK: when req_s=0, set ack<=0 and go to R_IDLE.
- Crossing-latency rule: each handshake edge takes SYNC_STAGES+1 cycles to reach the other side.
  - Transfer period with data_ready held high: 4*SYNC_STAGES+5 cycles (13 at default).
- First update: if data_ready is high before pclk edge E1, then:
  - rdy_s is high after edge E(SYNC_STAGES)
  - req rises at the next edge
  - data_out loads START_VAL at edge E(2*SYNC_STAGES+2), i.e. E6 at default.
- data_out changes only in the receiver's R_IDLE->R_ACK transition. It holds its value otherwise.
- data_ready falling:
  - Any in-flight handshake completes normally, including the data_out update and the increment.
  - No new req is raised while rdy_s=0 in S_IDLE.
  - When data_ready returns, transfers resume from the current src_data; no value is skipped or repeated.
- req never reasserts before ack_s has returned to 0, so four-phase ordering is always honoured.
- Each payload value is delivered exactly once.

Test Plan:
- Hold rst_n=0 for 2 edges, then release with data_ready=0 for 500 cycles -> data_out=0, req=ack=0 throughout.
- Raise data_ready (defaults) -> data_out=0 at the 6th edge after the first sampling edge, then 1, 2, 3... each exactly 13 cycles apart.
- Hold data_ready high for 65 transfers -> data_out sequence 0..63 then 0 (wrap), with no gaps or repeats.
- Drop data_ready one cycle after req rises -> that transfer still completes (data_out=N, next src_data=N+1) and no further updates occur. Re-raising data_ready -> next data_out=N+1.
- Pulse rst_n=0 for one edge while in S_REQ -> data_out=0 and src_data=START_VAL, and the next delivered value is START_VAL.
- SYNC_STAGES=3, START_VAL=5 -> first data_out=5 at edge E8, then updates every 17 cycles.

Source files
------------

// File: rtl/cdc_handshake_sync.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_sync
// Brief    : Single-clock model of a four-phase req/ack CDC handshake that
//            moves an incrementing payload from a sender to a receiver.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_handshake_sync #(
    parameter int DATA_W      = 6,
    parameter int SYNC_STAGES = 2,
    parameter int START_VAL   = 0
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WACK = 2'd2
    } snd_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rcv_state_t;

    localparam logic [DATA_W-1:0] C_START = DATA_W'(START_VAL);

    snd_state_t              r_snd_state;
    snd_state_t              w_snd_next;
    rcv_state_t              r_rcv_state;
    rcv_state_t              w_rcv_next;

    logic [SYNC_STAGES-1:0]  r_rdy_sync;
    logic [SYNC_STAGES-1:0]  r_req_sync;
    logic [SYNC_STAGES-1:0]  r_ack_sync;
    logic                    r_req;
    logic                    r_ack;
    logic [DATA_W-1:0]       r_src_data;
    logic [DATA_W-1:0]       r_data_out;

    logic                    w_rdy_s;
    logic                    w_req_s;
    logic                    w_ack_s;
    logic                    w_req_rise;
    logic                    w_req_fall;
    logic                    w_ack_rise;
    logic                    w_ack_fall;

    assign w_rdy_s  = r_rdy_sync[SYNC_STAGES-1];
    assign w_req_s  = r_req_sync[SYNC_STAGES-1];
    assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];
    assign data_out = r_data_out;

    // Each handshake edge spends one cycle in its source flop plus
    // SYNC_STAGES cycles in the destination synchronizer.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_rdy_sync <= '0;
            r_req_sync <= '0;
            r_ack_sync <= '0;
        end else begin
            r_rdy_sync <= {r_rdy_sync[SYNC_STAGES-2:0], data_ready};
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], r_req};
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_ack};
        end
    end

    always_comb begin
        w_snd_next = r_snd_state;
        w_req_rise = 1'b0;
        w_req_fall = 1'b0;
        case (r_snd_state)
            S_IDLE: begin
                if (w_rdy_s) begin
                    w_snd_next = S_REQ;
                    w_req_rise = 1'b1;
                end
            end
            S_REQ: begin
                if (w_ack_s) begin
                    w_snd_next = S_WACK;
                    w_req_fall = 1'b1;
                end
            end
            S_WACK: begin
                // Wait for ack to drop so req never overlaps a stale ack.
                if (!w_ack_s) begin
                    w_snd_next = S_IDLE;
                end
            end
            default: w_snd_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rcv_next = r_rcv_state;
        w_ack_rise = 1'b0;
        w_ack_fall = 1'b0;
        case (r_rcv_state)
            R_IDLE: begin
                if (w_req_s) begin
                    w_rcv_next = R_ACK;
                    w_ack_rise = 1'b1;
                end
            end
            R_ACK: begin
                if (!w_req_s) begin
                    w_rcv_next = R_IDLE;
                    w_ack_fall = 1'b1;
                end
            end
            default: w_rcv_next = R_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_snd_state <= S_IDLE;
            r_req       <= 1'b0;
            r_src_data  <= C_START;
        end else begin
            r_snd_state <= w_snd_next;
            if (w_req_rise) begin
                r_req <= 1'b1;
            end
            if (w_req_fall) begin
                r_req      <= 1'b0;
                r_src_data <= r_src_data + DATA_W'(1);
            end
        end
    end

    // src_data is held stable throughout S_REQ, so sampling it here is safe.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_rcv_state <= R_IDLE;
            r_ack       <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_rcv_state <= w_rcv_next;
            if (w_ack_rise) begin
                r_ack      <= 1'b1;
                r_data_out <= r_src_data;
            end
            if (w_ack_fall) begin
                r_ack <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_handshake_sync
// Brief    : Self-checking bench; expected data_out timeline is scheduled
//            into scoreboard queues and checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_sync;

    localparam int DW = 6;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        int          cycles;
        logic [DW-1:0] exp;
    } step_t;

    typedef struct {
        int            e;
        logic [DW-1:0] v;
    } sb_t;

    logic          pclk = 1'b0;
    logic          rst_n;
    logic          data_ready;
    logic [DW-1:0] data_out;
    logic          rst2_n;
    logic          rdy2;
    logic [DW-1:0] data_out2;

    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    logic          mon_en = 1'b0;
    logic [DW-1:0] exp1 = '0;
    logic [DW-1:0] exp2 = '0;
    sb_t           q1[$];
    sb_t           q2[$];
    step_t         steps[2];

    cdc_handshake_sync #(.DATA_W(DW), .SYNC_STAGES(2), .START_VAL(0)) u_dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .data_ready (data_ready),
        .data_out   (data_out)
    );

    cdc_handshake_sync #(.DATA_W(DW), .SYNC_STAGES(3), .START_VAL(5)) u_dut3 (
        .pclk       (pclk),
        .rst_n      (rst2_n),
        .data_ready (rdy2),
        .data_out   (data_out2)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc++;

    // Apply scheduled updates due at or before the latest edge, then compare.
    always @(negedge pclk) begin
        if (mon_en) begin
            while (q1.size() > 0 && q1[0].e <= cyc) exp1 = q1.pop_front().v;
            while (q2.size() > 0 && q2[0].e <= cyc) exp2 = q2.pop_front().v;
            total++;
            if (data_out !== exp1) begin
                bad++;
                $display("FAIL data_out edge=%0d got=%0d want=%0d", cyc, data_out, exp1);
            end
            total++;
            if (data_out2 !== exp2) begin
                bad++;
                $display("FAIL data_out_s3 edge=%0d got=%0d want=%0d", cyc, data_out2, exp2);
            end
        end
    end

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge pclk);
    endtask

    task automatic push1(input int e, input logic [DW-1:0] v);
        sb_t s;
        s.e = e;
        s.v = v;
        q1.push_back(s);
    endtask

    task automatic push2(input int e, input logic [DW-1:0] v);
        sb_t s;
        s.e = e;
        s.v = v;
        q2.push_back(s);
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    initial begin
        int c;
        int r;
        rst_n      = 1'b0;
        data_ready = 1'b0;
        rst2_n     = 1'b0;
        rdy2       = 1'b0;

        steps[0] = '{rst_n: 1'b0, rdy: 1'b0, cycles: 2,   exp: '0};
        steps[1] = '{rst_n: 1'b1, rdy: 1'b0, cycles: 500, exp: '0};

        // Reset and idle phase
        @(negedge pclk);
        for (int i = 0; i < 2; i++) begin
            rst_n      = steps[i].rst_n;
            data_ready = steps[i].rdy;
            repeat (steps[i].cycles) @(negedge pclk);
            check($sformatf("step%0d_data_out", i), int'(data_out), int'(steps[i].exp));
            mon_en = 1'b1;
        end

        // 66 back-to-back transfers: 0..63, wrap to 0, then 1
        c = cyc;
        data_ready = 1'b1;
        for (int k = 0; k < 66; k++) push1(c + 6 + 13 * k, DW'(k));
        // Drop data_ready one cycle after req rises for the last transfer
        wait_until(c + 3 + 13 * 65 + 1);
        data_ready = 1'b0;
        wait_until(c + 6 + 13 * 65 + 60);
        check("q1_drained_after_drop", q1.size(), 0);
        check("held_after_drop", int'(data_out), 1);

        // Resume: continues from 2 with no skip or repeat
        c = cyc;
        data_ready = 1'b1;
        push1(c + 6, DW'(2));
        push1(c + 19, DW'(3));

        // Reset pulse while the sender is in S_REQ for value 4
        r = c + 3 + 26;
        wait_until(r + 1);
        check("pre_reset_data_out", int'(data_out), 3);
        rst_n = 1'b0;
        q1.delete();
        push1(r + 2, DW'(0));
        push1(r + 8, DW'(0));
        push1(r + 21, DW'(1));
        wait_until(r + 2);
        rst_n = 1'b1;
        wait_until(r + 26);
        data_ready = 1'b0;
        check("q1_drained_after_reset", q1.size(), 0);
        check("post_reset_data_out", int'(data_out), 1);

        // SYNC_STAGES=3, START_VAL=5 instance
        c = cyc;
        rst2_n = 1'b1;
        rdy2   = 1'b1;
        push2(c + 8, DW'(5));
        push2(c + 25, DW'(6));
        push2(c + 42, DW'(7));
        wait_until(c + 50);
        check("q2_drained", q2.size(), 0);
        check("s3_final_data_out", int'(data_out2), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
